vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 110 +++++++++++
 tb/tb_vga_timing_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster timing with a registered DAC stage.
//   clk, rst (async, active-low), pix_ce (pixel-rate enable)
//   pixel_r/g/b  : colour from the draw stage for the current pixel_x/pixel_y
//   pixel_x/y    : raster counters (registered), video_on (combinational decode)
//   frame_start  : one-clk pulse after the (last,last) -> (0,0) wrap
//   vga_hs/vs, vga_blank_n, vga_r/g/b : DAC-side outputs, one pix_ce period
//                  behind pixel_x/pixel_y so sync, blank and colour line up.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  input  logic [7:0] pixel_r,
  input  logic [7:0] pixel_g,
  input  logic [7:0] pixel_b,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       frame_start,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        fs_q, fs_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic        blank_n_q, blank_n_d;
  logic [23:0] rgb_q, rgb_d;

  logic h_wrap, v_wrap, hsync, vsync;

  assign h_wrap   = (x_q == H_LAST);
  assign v_wrap   = (y_q == V_LAST);
  assign video_on = (x_q < H_VIS) && (y_q < V_VIS);
  assign hsync    = (x_q >= HS_START) && (x_q < HS_END);
  assign vsync    = (y_q >= VS_START) && (y_q < VS_END);

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    fs_d      = 1'b0;  // pulse clears on any clk, enabled or not
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    rgb_d     = rgb_q;
    if (pix_ce) begin
      x_d = h_wrap ? 10'd0 : x_q + 10'd1;
      if (h_wrap) y_d = v_wrap ? 10'd0 : y_q + 10'd1;
      fs_d      = h_wrap && v_wrap;
      // Output stage samples the pre-edge position, giving the one-period lag.
      hs_d      = hsync ? SYNC_POL : ~SYNC_POL;
      vs_d      = vsync ? SYNC_POL : ~SYNC_POL;
      blank_n_d = video_on;
      rgb_d     = video_on ? {pixel_r, pixel_g, pixel_b} : 24'h0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q       <= 10'd0;
      y_q       <= 10'd0;
      fs_q      <= 1'b0;
      hs_q      <= ~SYNC_POL;
      vs_q      <= ~SYNC_POL;
      blank_n_q <= 1'b0;
      rgb_q     <= 24'h0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      fs_q      <= fs_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      rgb_q     <= rgb_d;
    end
  end

  assign pixel_x              = x_q;
  assign pixel_y              = y_q;
  assign frame_start          = fs_q;
  assign vga_hs               = hs_q;
  assign vga_vs               = vs_q;
  assign vga_blank_n          = blank_n_q;
  assign {vga_r, vga_g, vga_b} = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a shrunken raster (25 x 17) so whole frames
// fit in a short run. Two instances share stimulus: SYNC_POL=0 and SYNC_POL=1.
module tb_vga_timing_gen;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;  // 25
  localparam int VT = VA + VF + VS + VB;  // 17
  localparam int FR = HT * VT;            // 425

  logic clk = 1'b0, rst = 1'b0, pix_ce = 1'b0;
  logic [7:0] pr = 8'h0, pg = 8'h0, pb = 8'h0;

  logic [9:0] x0, y0, x1, y1;
  logic von0, fs0, hs0, vs0, bl0, von1, fs1, hs1, vs1, bl1;
  logic [7:0] r0, g0, b0, r1, g1, b1;

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                   .SYNC_POL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .pixel_r(pr), .pixel_g(pg), .pixel_b(pb),
    .pixel_x(x0), .pixel_y(y0), .video_on(von0), .frame_start(fs0),
    .vga_hs(hs0), .vga_vs(vs0), .vga_blank_n(bl0),
    .vga_r(r0), .vga_g(g0), .vga_b(b0));

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                   .SYNC_POL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .pixel_r(pr), .pixel_g(pg), .pixel_b(pb),
    .pixel_x(x1), .pixel_y(y1), .video_on(von1), .frame_start(fs1),
    .vga_hs(hs1), .vga_vs(vs1), .vga_blank_n(bl1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // Reference model: the raster is just "number of enabled edges since reset".
  int          m_t;
  bit          m_fs, m_hsi, m_vsi, m_blank;
  logic [23:0] m_rgb;

  function automatic int mx(int t); return t % HT; endfunction
  function automatic int my(int t); return (t / HT) % VT; endfunction
  function automatic bit vis(int t); return mx(t) < HA && my(t) < VA; endfunction
  function automatic bit hwin(int t); return mx(t) >= HA + HF && mx(t) < HA + HF + HS; endfunction
  function automatic bit vwin(int t); return my(t) >= VA + VF && my(t) < VA + VF + VS; endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_fs = 0; m_hsi = 0; m_vsi = 0; m_blank = 0; m_rgb = 24'h0;
  endtask

  task automatic check_all();
    chk("pixel_x", int'(x0), mx(m_t));
    chk("pixel_y", int'(y0), my(m_t));
    chk("video_on", int'(von0), int'(vis(m_t)));
    chk("frame_start", int'(fs0), int'(m_fs));
    chk("vga_hs", int'(hs0), m_hsi ? 0 : 1);
    chk("vga_vs", int'(vs0), m_vsi ? 0 : 1);
    chk("vga_blank_n", int'(bl0), int'(m_blank));
    chk("vga_rgb", int'({r0, g0, b0}), int'(m_rgb));
    chk("pol1_hs", int'(hs1), m_hsi ? 1 : 0);
    chk("pol1_vs", int'(vs1), m_vsi ? 1 : 0);
    chk("pol1_xy", int'({x1, y1}), int'({x0, y0}));
    chk("pol1_other", int'({von1, fs1, bl1, r1, g1, b1}),
        int'({vis(m_t), m_fs, m_blank, m_rgb}));
  endtask

  // Called at a negedge: drive inputs, predict the next posedge, check at the next negedge.
  task automatic step(input bit ce, input bit pat);
    pix_ce = ce;
    if (pat) {pr, pg, pb} = {x0[7:0], y0[7:0], 8'hA5};
    else     {pr, pg, pb} = 24'($urandom);
    if (ce) begin
      m_hsi   = hwin(m_t);
      m_vsi   = vwin(m_t);
      m_blank = vis(m_t);
      m_rgb   = vis(m_t) ? {pr, pg, pb} : 24'h0;
      m_t++;
      m_fs    = (m_t % FR) == 0;
    end else begin
      m_fs = 0;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; pix_ce = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b1;
    check_all();
  endtask

  typedef struct { int n; int x; int y; bit von; bit hs; bit fs; } vec_t;
  vec_t tbl[14];

  initial begin
    int fs_a, fs_b, fs_cnt, hs_low, vs_low, vs_first_y;

    // n enabled edges after reset -> expected position, decode, registered hs and pulse
    tbl[0]  = '{0,   0,  0, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1,   1,  0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{15,  15, 0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{16,  16, 0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{18,  18, 0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{19,  19, 0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{22,  22, 0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{23,  23, 0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{25,  0,  1, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{249, 24, 9, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{250, 0, 10, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{424, 24, 16, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{425, 0,  0, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{426, 1,  0, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 14; i++) begin
      do_reset();
      repeat (tbl[i].n) step(1'b1, 1'b0);
      chk($sformatf("tbl%0d_x", i), int'(x0), tbl[i].x);
      chk($sformatf("tbl%0d_y", i), int'(y0), tbl[i].y);
      chk($sformatf("tbl%0d_von", i), int'(von0), int'(tbl[i].von));
      chk($sformatf("tbl%0d_hs", i), int'(hs0), int'(tbl[i].hs));
      chk($sformatf("tbl%0d_fs", i), int'(fs0), int'(tbl[i].fs));
    end

    // Two frames, constant enable.
    do_reset();
    fs_a = -1; fs_b = -1; fs_cnt = 0; hs_low = 0; vs_low = 0; vs_first_y = -1;
    for (int i = 1; i <= 2 * FR; i++) begin
      step(1'b1, 1'b1);
      if (fs0) begin fs_cnt++; if (fs_a < 0) fs_a = i; else fs_b = i; end
      if (!hs0) hs_low++;
      if (!vs0) begin vs_low++; if (vs_first_y < 0) vs_first_y = int'(y0); end
    end
    chk("const_fs_count", fs_cnt, 2);
    chk("const_fs_period", fs_b - fs_a, FR);
    chk("const_hs_low", hs_low, 2 * VT * HS);
    chk("const_vs_low", vs_low, 2 * VS * HT);
    chk("const_vs_first_y", vs_first_y, VA + VF);

    // Two frames of edges with enable toggling 1,0,1,0.
    do_reset();
    fs_a = -1; fs_b = -1; fs_cnt = 0; hs_low = 0; vs_low = 0;
    for (int i = 1; i <= 4 * FR; i++) begin
      step(i % 2 == 1, 1'b1);
      if (fs0) begin fs_cnt++; if (fs_a < 0) fs_a = i; else fs_b = i; end
      if (!hs0) hs_low++;
      if (!vs0) vs_low++;
    end
    chk("tog_fs_count", fs_cnt, 2);
    chk("tog_fs_period", fs_b - fs_a, 2 * FR);
    chk("tog_hs_low", hs_low, 4 * VT * HS);
    chk("tog_vs_low", vs_low, 4 * VS * HT);

    // Reset mid-frame at (12,5): outputs forced without a clock edge.
    do_reset();
    repeat (5 * HT + 12) step(1'b1, 1'b1);
    chk("mid_x_before", int'(x0), 12);
    chk("mid_y_before", int'(y0), 5);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_xy", int'({x0, y0}), 0);
    chk("mid_rst_fs", int'(fs0), 0);
    chk("mid_rst_sync", int'({hs0, vs0, hs1, vs1}), 4'b1100);
    chk("mid_rst_blank", int'(bl0), 0);
    chk("mid_rst_rgb", int'({r0, g0, b0}), 0);
    chk("mid_rst_von", int'(von0), 1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b1);
    chk("mid_first_x", int'(x0), 1);
    fs_cnt = 0;
    repeat (FR - 2) begin step(1'b1, 1'b0); if (fs0) fs_cnt++; end
    chk("mid_no_early_fs", fs_cnt, 0);
    step(1'b1, 1'b0);
    chk("mid_fs_at_wrap", int'(fs0), 1);

    // Randomised enable and colour, checked every cycle against the model.
    do_reset();
    repeat (2500) step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
